spxpm_stream: RTL
=================

# spxpm_stream

Read-side initiator for a synchronous single-port ROM with one-cycle read latency: walks a contiguous, wrapping address range and presents each ROM word on a valid/ready output stream. Sits between a control agent (boot loader, microcode or table sequencer) issuing (base, length) requests and a ROM instance, absorbing ROM latency and output backpressure without losing or duplicating words.

## Interface
- A, 6: ROM address width; ROM depth is 2**A words.
- D, 32: ROM data and output stream width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_base  in  A  first ROM address.
- req_len  in  A+1  word count, 0..2**A.
- rom_en  out  1  ROM read enable.
- rom_addr  out  A  ROM read address.
- rom_data  in  D  ROM read data, valid the cycle after rom_en.
- out_valid  out  1  output word present.
- out_ready  in  1  consumer accepts word.
- out_data  out  D  ROM word.
- out_last  out  1  marks final word of the request.
- busy  out  1  request in progress (state != IDLE).

## Operation
- States IDLE, RUN, DRAIN.
- IDLE: req_ready=1. On req_valid&req_ready latch addr=req_base, rem=req_len, idx=0; go RUN if req_len!=0; else stay IDLE (no words, no ROM access).
- RUN: issue a read (rom_en=1, rom_addr=addr) when rem!=0 and occ + infl - pop < 2, where occ = buffer occupancy (0..2), infl = read issued last cycle, pop = out_valid&out_ready. On issue: addr <= addr+1 mod 2**A (wraps 2**A-1 -> 0), rem <= rem-1. Issue of final read (rem==1) -> DRAIN.
- Buffer: 2-entry FIFO. Cycle after an issue, rom_data written with last flag = (word index == len-1). Head drives out_data/out_last.
- DRAIN: no issues; -> IDLE in the cycle after the last-flagged word is popped and infl=0.
- rom_en=0 outside issue cycles; rom_addr holds last value when idle (don't-care, not checked).
- Simultaneous push and pop on a full buffer is legal (occupancy unchanged); issue rule guarantees push never meets a full buffer without pop.
- req_len=2**A reads every location exactly once, starting at req_base, wrapping.
- out_valid never deasserts before handshake; out_data/out_last stable while out_valid&!out_ready.

## Timing
- Reset (rst=0 at an edge): state IDLE, occ=0, infl=0, rem=0. Outputs after that edge: req_ready=1, rom_en=0, out_valid=0, out_last=0, busy=0, out_data=0. Reset mid-request aborts it; buffered and in-flight words are discarded, no output produced for them.
- Request accepted in cycle 0 -> first rom_en in cycle 1 -> rom_data cycle 2 -> out_valid cycle 3.
- With out_ready held high: one word per cycle; N-word request occupies cycles 1..N with rom_en, outputs in cycles 3..N+2, req_ready back in cycle N+3.
- out_ready -> rom_en is the only combinational input-to-output path; req_ready, out_* are registered or derived from registered state.
- Back-to-back requests: minimum gap of one IDLE cycle after DRAIN.

## Structure
- Shared package spxpm_pkg: state enum (IDLE, RUN, DRAIN), buffer depth constant (2).
- Sub-module spxpm_fifo2: 2-entry FIFO of {last, data} with push, pop, occ, head outputs; all control (counters, FSM, issue rule) stays in spxpm_stream.

## Test plan
- Reset then req base=0x04 len=4, out_ready=1 -> rom_en cycles 1-4 addrs 4,5,6,7; out_data = ROM[4..7] cycles 3-6; out_last only on ROM[7]; req_ready high cycle 7.
- Wrap: base=0x3E len=4 (A=6) -> addresses 0x3E,0x3F,0x00,0x01 in order, 4 words, last on ROM[1].
- Backpressure: len=8, out_ready low cycles 3-9 -> out_valid held, out_data stable at ROM[base], never more than 2 reads outstanding beyond pops; all 8 words delivered in order, none duplicated.
- Zero/full length: len=0 -> no rom_en, no out_valid, req_ready stays 1; len=64 base=0x10 -> 64 distinct addresses each read once.
- Reset mid-request: rst=0 in cycle 4 of len=16 -> following cycle out_valid=0, rom_en=0, req_ready=1, busy=0; new request len=2 delivers exactly 2 words.
- Random out_ready toggling over 200 requests vs. reference model -> stream matches ROM contents, out_last exactly once per nonzero request.

Source files
------------

// File: rtl/spxpm_pkg.sv
// Shared types and constants for the spxpm ROM streaming reader.
package spxpm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Output skid buffer depth; covers one word in flight plus one waiting.
  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/spxpm_fifo2.sv
// Two-entry FIFO holding {last, data} words returned by the ROM.
module spxpm_fifo2
  import spxpm_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [1:0]   o_occ,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [BUF_DEPTH];
  logic         r_rp;
  logic         r_wp;
  logic [1:0]   r_occ;

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rp     <= 1'b0;
      r_wp     <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= ~r_wp;
      end
      if (i_pop) r_rp <= ~r_rp;
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ  = r_occ;
  assign o_head = r_mem[r_rp];

endmodule

// File: rtl/spxpm_stream.sv
// Walks a wrapping ROM address range and streams each word out on valid/ready,
// hiding the one-cycle ROM latency behind a two-entry buffer.
module spxpm_stream
  import spxpm_pkg::*;
#(
  parameter int A = 6,
  parameter int D = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [A-1:0] req_base,
  input  logic [A:0]   req_len,
  output logic         rom_en,
  output logic [A-1:0] rom_addr,
  input  logic [D-1:0] rom_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [D-1:0] out_data,
  output logic         out_last,
  output logic         busy
);

  state_t       r_state;
  state_t       w_next;
  logic [A-1:0] r_addr;
  logic [A:0]   r_rem;
  logic         r_infl;
  logic         r_infl_last;

  logic [1:0]   w_occ;
  logic [D:0]   w_head;
  logic         w_pop;
  logic         w_issue;
  logic         w_accept;

  assign out_valid = (w_occ != 2'd0);
  assign w_pop     = out_valid & out_ready;
  assign w_accept  = req_valid & (r_state == ST_IDLE);
  // A read may go out only if the buffer can still take it once the in-flight word lands.
  assign w_issue   = (r_state == ST_RUN) && (r_rem != '0) &&
                     (({1'b0, w_occ} + {2'b0, r_infl}) < (3'd2 + {2'b0, w_pop}));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid && (req_len != '0)) w_next = ST_RUN;
      ST_RUN:   if (w_issue && (r_rem == (A+1)'(1))) w_next = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_head[D] && !r_infl) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready = (r_state == ST_IDLE);
    busy      = (r_state != ST_IDLE);
    rom_en    = w_issue;
  end

  // Address walker, remaining count and in-flight tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr      <= '0;
      r_rem       <= '0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_infl      <= w_issue;
      r_infl_last <= w_issue && (r_rem == (A+1)'(1));
      if (w_accept) begin
        r_addr <= req_base;
        r_rem  <= req_len;
      end else if (w_issue) begin
        r_addr <= r_addr + A'(1);
        r_rem  <= r_rem - (A+1)'(1);
      end
    end
  end

  assign rom_addr = r_addr;

  spxpm_fifo2 #(.W(D + 1)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_infl),
    .i_din  ({r_infl_last, rom_data}),
    .i_pop  (w_pop),
    .o_occ  (w_occ),
    .o_head (w_head)
  );

  assign out_data = w_head[D-1:0];
  assign out_last = out_valid & w_head[D];

endmodule
